// File: rtl/raster_slot_sequencer_pkg.sv
// Raster timing defaults, counter widths and slot scheduler state type
// shared by the raster slot sequencer files.
package raster_pkg;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_SLOT_START = 8;
  localparam int DEF_SLOT_LEN   = 4;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP
                         + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP
                         + DEF_V_SYNC + DEF_V_BP;

  localparam int XW  = 10;
  localparam int YW  = 10;
  localparam int FCW = 8;

  typedef enum logic {
    IDLE,
    GRANT
  } slot_state_e;

endpackage

// File: rtl/raster_slot_sequencer_if.sv
// Raster timing outputs plus the audio datapath request/grant pair.
interface raster_slot_sequencer_if;
  import raster_pkg::*;

  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic           active;
  logic           hsync;
  logic           vsync;
  logic           new_line;
  logic           new_frame;
  logic           audio_req;
  logic           audio_grant;
  logic           video_grant;
  logic [FCW-1:0] frame_count;

  modport master (
    output x, y, active, hsync, vsync,
    output new_line, new_frame,
    output audio_grant, video_grant,
    output frame_count,
    input  audio_req
  );

  modport slave (
    input  x, y, active, hsync, vsync,
    input  new_line, new_frame,
    input  audio_grant, video_grant,
    input  frame_count,
    output audio_req
  );

endinterface

// File: rtl/raster_slot_sequencer_counter.sv
// Raster x/y counters with zero-latency sync/active/strobe decode.
// FRAME_COUNTER_EN adds an 8-bit completed-frame counter.
module raster_counter
  import raster_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic           clk_i,
  input  logic           reset_i,
  output logic [XW-1:0]  x_o,
  output logic [YW-1:0]  y_o,
  output logic           active_o,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic           new_line_o,
  output logic           new_frame_o,
  output logic [FCW-1:0] frame_count_o
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] X_LAST = XW'(HT - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_HS0  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] X_HS1  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] Y_LAST = YW'(VT - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_VS0  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] Y_VS1  = YW'(V_ACTIVE + V_FP + V_SYNC);

  if (HT > (1 << XW) || VT > (1 << YW)) begin : g_bad_size
    $error("raster totals exceed counter width");
  end

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_wrap;
  logic          y_wrap;

  assign x_wrap = (x_q == X_LAST);
  assign y_wrap = (y_q == Y_LAST);

  always_comb begin
    x_d = x_wrap ? '0 : x_q + XW'(1);
    y_d = y_q;
    if (x_wrap) begin
      y_d = y_wrap ? '0 : y_q + YW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o         = x_q;
  assign y_o         = y_q;
  assign active_o    = (x_q < X_ACT) && (y_q < Y_ACT);
  assign hsync_o     = !((x_q >= X_HS0) && (x_q < X_HS1));
  assign vsync_o     = !((y_q >= Y_VS0) && (y_q < Y_VS1));
  assign new_line_o  = !reset_i && (x_q == '0);
  assign new_frame_o = !reset_i && (x_q == '0) && (y_q == '0);

`ifdef FRAME_COUNTER_EN
  logic [FCW-1:0] fc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fc_q <= '0;
    end else if (x_wrap && y_wrap) begin
      fc_q <= fc_q + FCW'(1);
    end
  end

  assign frame_count_o = fc_q;
`else
  assign frame_count_o = '0;
`endif

endmodule

// File: rtl/raster_slot_sequencer.sv
// VGA raster timing plus audio slot scheduler for the shared datapath.
// FRAME_COUNTER_EN enables frame_count; otherwise it reads 0.
module raster_slot_sequencer
  import raster_pkg::*;
#(
  parameter int H_ACTIVE         = DEF_H_ACTIVE,
  parameter int H_FP             = DEF_H_FP,
  parameter int H_SYNC           = DEF_H_SYNC,
  parameter int H_BP             = DEF_H_BP,
  parameter int V_ACTIVE         = DEF_V_ACTIVE,
  parameter int V_FP             = DEF_V_FP,
  parameter int V_SYNC           = DEF_V_SYNC,
  parameter int V_BP             = DEF_V_BP,
  parameter int AUDIO_SLOT_START = DEF_SLOT_START,
  parameter int AUDIO_SLOT_LEN   = DEF_SLOT_LEN
) (
  input logic clk,
  input logic reset,
  raster_slot_sequencer_if.master bus
);

  localparam int CW = (AUDIO_SLOT_LEN > 1) ?
                      $clog2(AUDIO_SLOT_LEN) : 1;

  // Decide on the cycle before slot start so the registered grant
  // lines up exactly with x == H_ACTIVE + AUDIO_SLOT_START.
  localparam logic [XW-1:0] X_PRE =
    XW'(H_ACTIVE + AUDIO_SLOT_START - 1);
  localparam logic [CW-1:0] C_LOAD = CW'(AUDIO_SLOT_LEN - 1);

  if (AUDIO_SLOT_LEN < 1 ||
      AUDIO_SLOT_START + AUDIO_SLOT_LEN >
      H_FP + H_SYNC + H_BP) begin : g_bad_slot
    $error("audio slot does not fit in horizontal blanking");
  end

  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [FCW-1:0] fc;
  logic           act, hs, vs, nl, nf;

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_counter (
    .clk_i         (clk),
    .reset_i       (reset),
    .x_o           (x),
    .y_o           (y),
    .active_o      (act),
    .hsync_o       (hs),
    .vsync_o       (vs),
    .new_line_o    (nl),
    .new_frame_o   (nf),
    .frame_count_o (fc)
  );

  slot_state_e   state_q, state_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          want;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | bus.audio_req;
    cnt_d     = cnt_q;
    want      = pending_q | bus.audio_req;
    unique case (state_q)
      IDLE: begin
        if (want && (x == X_PRE)) begin
          state_d   = GRANT;
          pending_d = 1'b0;
          cnt_d     = C_LOAD;
        end
      end
      GRANT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.x           = x;
  assign bus.y           = y;
  assign bus.active      = act;
  assign bus.hsync       = hs;
  assign bus.vsync       = vs;
  assign bus.new_line    = nl;
  assign bus.new_frame   = nf;
  assign bus.frame_count = fc;
  assign bus.audio_grant = (state_q == GRANT);
  assign bus.video_grant = (state_q != GRANT);

endmodule

// File: tb/tb_raster_slot_sequencer.sv
// Directed bench: raster timing vectors plus audio slot sequences.
module tb_raster_slot_sequencer;
  import raster_pkg::*;

  localparam int VA  = 12;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int HT  = 800;

  logic clk;
  logic reset;
  raster_slot_sequencer_if bus ();

  raster_slot_sequencer #(
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VS),
    .V_BP     (VBP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int f;
    int x;
    int y;
    bit act;
    bit hs;
    bit vs;
    bit nl;
    bit nf;
  } vec_t;

  vec_t tbl [21];

  int checks;
  int errors;
  int tcyc;
  bit counting;
  int n_nl, n_nf, n_act, n_hs, n_vs;

  task automatic sample();
    if (bus.new_line) n_nl++;
    if (bus.new_frame) n_nf++;
    if (bus.active) n_act++;
    if (!bus.hsync) n_hs++;
    if (!bus.vsync) n_vs++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tcyc++;
    checks++;
    assert (!(bus.audio_grant && bus.active) &&
            bus.video_grant === ~bus.audio_grant)
    else begin
      $display("FAIL grant_excl t=%0d ag=%0b vg=%0b act=%0b",
               tcyc, bus.audio_grant, bus.video_grant, bus.active);
      errors++;
    end
    if (counting) sample();
  endtask

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      errors++;
    end
  endtask

  task automatic goto_pos(input int gx, input int gy);
    int n;
    n = 0;
    while (!(int'(bus.x) == gx && int'(bus.y) == gy) && n < 20000) begin
      step();
      n++;
    end
    chk($sformatf("reach_%0d_%0d", gx, gy), 64'(n < 20000), 64'd1);
  endtask

  // Runs to the end of the current line, pulsing audio_req at the
  // given x positions, and reports where the grant started and its length.
  task automatic scan_line(input int p0, input int p1,
                           input int p2, input int p3,
                           output int first, output int cnt);
    int n;
    int cx;
    first = -1;
    cnt = 0;
    n = 0;
    do begin
      cx = int'(bus.x);
      bus.audio_req = (cx == p0 || cx == p1 || cx == p2 || cx == p3);
      if (bus.audio_grant) begin
        if (first < 0) first = cx;
        cnt++;
      end
      step();
      n++;
    end while (bus.x != '0 && n < 900);
    bus.audio_req = 1'b0;
    chk("scan_bound", 64'(n < 900), 64'd1);
  endtask

  task automatic line_chk(input string name, input int p0,
                          input int p1, input int p2, input int p3,
                          input int exp_first, input int exp_cnt);
    int fst, cnt;
    scan_line(p0, p1, p2, p3, fst, cnt);
    chk({name, "_first"}, 64'(fst), 64'(exp_first));
    chk({name, "_len"}, 64'(cnt), 64'(exp_cnt));
  endtask

  logic [32:0] got_v, exp_v;
  logic [7:0]  exp_fc;
  int          target;

  initial begin
    checks = 0;
    errors = 0;
    tcyc = 0;
    counting = 0;
    n_nl = 0; n_nf = 0; n_act = 0; n_hs = 0; n_vs = 0;

    tbl[0]  = '{0,   0,  0, 1, 1, 1, 1, 1};
    tbl[1]  = '{0,   1,  0, 1, 1, 1, 0, 0};
    tbl[2]  = '{0, 639,  0, 1, 1, 1, 0, 0};
    tbl[3]  = '{0, 640,  0, 0, 1, 1, 0, 0};
    tbl[4]  = '{0, 655,  0, 0, 1, 1, 0, 0};
    tbl[5]  = '{0, 656,  0, 0, 0, 1, 0, 0};
    tbl[6]  = '{0, 751,  0, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 752,  0, 0, 1, 1, 0, 0};
    tbl[8]  = '{0, 799,  0, 0, 1, 1, 0, 0};
    tbl[9]  = '{0,   0,  1, 1, 1, 1, 1, 0};
    tbl[10] = '{0, 700,  1, 0, 0, 1, 0, 0};
    tbl[11] = '{0, 639, 11, 1, 1, 1, 0, 0};
    tbl[12] = '{0,   0, 12, 0, 1, 1, 1, 0};
    tbl[13] = '{0, 799, 13, 0, 1, 1, 0, 0};
    tbl[14] = '{0,   0, 14, 0, 1, 0, 1, 0};
    tbl[15] = '{0, 700, 15, 0, 0, 0, 0, 0};
    tbl[16] = '{0,   0, 16, 0, 1, 1, 1, 0};
    tbl[17] = '{0, 799, 18, 0, 1, 1, 0, 0};
    tbl[18] = '{1,   0,  0, 1, 1, 1, 1, 1};
    tbl[19] = '{1, 640, 11, 0, 1, 1, 0, 0};
    tbl[20] = '{2,   0,  0, 1, 1, 1, 1, 1};

    reset = 1'b1;
    bus.audio_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",
        {bus.x, bus.y, bus.active, bus.hsync, bus.vsync,
         bus.new_line, bus.new_frame, bus.audio_grant,
         bus.video_grant, bus.frame_count},
        {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
         1'b0, 1'b1, 8'd0});

    reset = 1'b0;
    #1;
    tcyc = 0;
    counting = 1;
    sample();

    for (int i = 0; i < 21; i++) begin
      target = tbl[i].f * VT * HT + tbl[i].y * HT + tbl[i].x;
      while (tcyc < target) step();
`ifdef FRAME_COUNTER_EN
      exp_fc = 8'(tbl[i].f);
`else
      exp_fc = 8'd0;
`endif
      got_v = {bus.x, bus.y, bus.active, bus.hsync, bus.vsync,
               bus.new_line, bus.new_frame, bus.frame_count};
      exp_v = {10'(tbl[i].x), 10'(tbl[i].y), tbl[i].act,
               tbl[i].hs, tbl[i].vs, tbl[i].nl, tbl[i].nf, exp_fc};
      chk($sformatf("vec%0d", i), 64'(got_v), 64'(exp_v));
    end
    counting = 0;

    chk("cnt_new_line",  64'(n_nl),  64'(2 * VT + 1));
    chk("cnt_new_frame", 64'(n_nf),  64'd3);
    chk("cnt_active",    64'(n_act), 64'(2 * VA * 640 + 1));
    chk("cnt_hsync_lo",  64'(n_hs),  64'(2 * VT * 96));
    chk("cnt_vsync_lo",  64'(n_vs),  64'(2 * VS * HT));

    goto_pos(0, 10);
    line_chk("single_y10", 100, -1, -1, -1, 648, 4);
    line_chk("none_y11", -1, -1, -1, -1, -1, 0);
    line_chk("merged_y12", 100, 200, 300, 649, 648, 4);
    line_chk("deferred_y13", -1, -1, -1, -1, 648, 4);
    line_chk("none_y14", -1, -1, -1, -1, -1, 0);
    line_chk("vblank_y15", 100, -1, -1, -1, 648, 4);
    line_chk("edge_y16", 647, -1, -1, -1, 648, 4);
    line_chk("none_y17", -1, -1, -1, -1, -1, 0);
    line_chk("late_y18", 700, -1, -1, -1, -1, 0);
    line_chk("late_y0", -1, -1, -1, -1, 648, 4);

    goto_pos(100, 1);
    bus.audio_req = 1'b1;
    step();
    bus.audio_req = 1'b0;
    goto_pos(649, 1);
    bus.audio_req = 1'b1;
    step();
    bus.audio_req = 1'b0;
    chk("midslot_grant", 64'(bus.audio_grant), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("midslot_reset",
        {bus.x, bus.y, bus.audio_grant, bus.video_grant,
         bus.new_line, bus.new_frame, bus.frame_count},
        {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0});
    line_chk("post_reset_y0", -1, -1, -1, -1, -1, 0);
    line_chk("rereq_y1", 300, -1, -1, -1, 648, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
